tt_um_pwm_generator_verilog: RTL and testbench
==============================================

# tt_um_pwm_generator_verilog

Fixed-frequency PWM generator whose duty cycle is stepped in 10 % increments by two push-button inputs. Each button input passes through an on-chip tick-sampled debouncer, and each accepted press moves the duty cycle up or down by one step. The PWM period is 10 clock cycles. The block is a TinyTapeout-style user top: button inputs arrive on `ui_*` pins and the PWM waveform leaves on a `uo_*` pin.

## Interface
Parameters: none. All constants are fixed: period 10, duty range 0..10, reset duty 5, tick divider 4.

Ports:
- `clk`  input  1  system clock, 100 MHz nominal, rising-edge.
- `rst_n`  input  1  reset. One clock; reset is asynchronous and active-high. The `_n` in the name is the codebase port name only; asserted = 1.
- `ena`  input  1  design-enable from the harness. Has no functional effect; the block runs whenever it is out of reset.
- `ui_increase_duty`  input  1  raw "increase" button, active-high, asynchronous to `clk`, may bounce.
- `ui_decrease_duty`  input  1  raw "decrease" button, same properties as `ui_increase_duty`.
- `uo_PWM_OUT`  output  1  PWM waveform, registered.

## Operation
- **Tick prescaler:** 2-bit counter `pre` increments every clk and wraps 3→0. `tick` = (`pre` == 3), so it is asserted 1 cycle in 4.
- **Debouncer, one per button:**
  - Two-flop synchronizer on every clk.
  - Then a 3-bit shift register `s[2:0]` that shifts only on `tick`: `s <= {s[1:0], sync_out}`.
  - Press pulse = `tick` & `s[1]` & `s[0]` & ~`s[2]`, evaluated on the shifted values. The input must therefore be high on 2 consecutive ticks after being low.
  - The pulse is at most 1 clk wide, so exactly one pulse is produced per accepted press.
  - A release needs no action.
- **Duty register** `duty` (4 bits, range 0..10):
  - Increment pulse only: `duty` <= min(`duty` + 1, 10).
  - Decrement pulse only: `duty` <= max(`duty` − 1, 0).
  - Both pulses in the same cycle: no change.
  - No wrap-around in either direction.
- **Period counter** `cnt` (4 bits): counts 0..9 and wraps 9→0 every clk.
- **Output:** `uo_PWM_OUT` <= (`cnt` < `duty`), registered each clk.
  - `duty` = 0 gives a constant 0.
  - `duty` = 10 gives a constant 1.
  - `duty` = k gives k high cycles followed by 10−k low cycles per period.
- A duty change takes effect at the very next compare, even in mid-period. No period-boundary synchronization is applied.

## Timing
- **Reset values** (asynchronous, while `rst_n` = 1):
  - `pre` = 0, `cnt` = 0, `duty` = 5.
  - Synchronizer flops and `s` = 0.
  - `uo_PWM_OUT` = 0.
- **After reset release:**
  - The first rising edge makes `uo_PWM_OUT` = (0 < 5) = 1.
  - The output is then 5 high / 5 low, repeating every 10 clks.
- **Press latency:** from a button rising edge to the `duty` update is 2 sync cycles + 2 ticks, i.e. at most 2 + 8 + 1 clks (≤ 11 clks). `uo_PWM_OUT` reflects the new duty 1 clk later.
- **Minimum accepted press:** high for ≥ 2 consecutive ticks. 9 clks of stable high always suffices; 4 clks or fewer is never guaranteed.
- **Glitch rejection:** a glitch shorter than one tick spacing (4 clks) is never accepted.
- **Reset mid-operation:** all state returns immediately to the reset values, and any pending press is discarded.

## Test plan
- **Reset and default:** hold `rst_n` = 1 for 5 clks, then release → `uo_PWM_OUT` = 0 during reset; afterwards a period of 10 clks with exactly 5 high, repeating.
- **Three increments:** from reset, pulse `ui_increase_duty` high for 10 clks then low for 10 clks, three times → `duty` = 8; output has 8 high / 2 low per 10-clk period.
- **Three decrements:** continuing from the previous scenario, apply the same pulse pattern three times on `ui_decrease_duty` → `duty` = 5; output returns to 5 high / 5 low.
- **Saturation:**
  - 7 increment presses from reset → `duty` = 10; `uo_PWM_OUT` constantly 1. A further press leaves it unchanged.
  - 11 decrement presses → `duty` = 0; `uo_PWM_OUT` constantly 0.
- **Debounce and simultaneity:**
  - A 3-clk high glitch on `ui_increase_duty` → `duty` unchanged at 5.
  - Both buttons held high together for 12 clks → `duty` unchanged at 5.
  - A single 40-clk hold → exactly +1 (`duty` = 6).
- **Async reset mid-run:** with `duty` = 8, assert `rst_n` between clock edges → `uo_PWM_OUT` goes to 0 without waiting for a clk edge; after release, `duty` = 5.

Source files
------------

// File: rtl/tt_um_pwm_generator_verilog.sv
// tt_um_pwm_generator_verilog: 10-cycle PWM whose duty (0..10) is stepped by two debounced buttons
//   clk              rising-edge system clock
//   rst_n            asynchronous reset, active-high despite the name
//   ena              harness enable, no functional effect
//   ui_increase_duty raw increase button (async, may bounce)
//   ui_decrease_duty raw decrease button (async, may bounce)
//   uo_PWM_OUT       registered PWM waveform
module tt_um_pwm_generator_verilog (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic ui_increase_duty,
  input  logic ui_decrease_duty,
  output logic uo_PWM_OUT
);
  logic [1:0] pre_q;
  logic [1:0] meta_q, sync_q;
  logic [2:0] inc_sh_q, inc_sh_d, dec_sh_q, dec_sh_d;
  logic [3:0] cnt_q, cnt_d, duty_q, duty_d;
  logic       pwm_q, tick, inc_p, dec_p;
  logic       unused_ena;
  assign unused_ena = ena;
  assign tick = pre_q == 2'd3;
  assign inc_sh_d = tick ? {inc_sh_q[1:0], sync_q[0]} : inc_sh_q;
  assign dec_sh_d = tick ? {dec_sh_q[1:0], sync_q[1]} : dec_sh_q;
  // a press is a 0->1->1 pattern over three tick samples, seen on the freshly shifted value
  assign inc_p = tick & inc_sh_d[1] & inc_sh_d[0] & ~inc_sh_d[2];
  assign dec_p = tick & dec_sh_d[1] & dec_sh_d[0] & ~dec_sh_d[2];
  always_comb begin
    cnt_d  = cnt_q == 4'd9 ? 4'd0 : cnt_q + 4'd1;
    duty_d = (inc_p & ~dec_p & duty_q != 4'd10) ? duty_q + 4'd1 :
             (dec_p & ~inc_p & duty_q != 4'd0)  ? duty_q - 4'd1 : duty_q;
  end
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      pre_q    <= '0;
      meta_q   <= '0;
      sync_q   <= '0;
      inc_sh_q <= '0;
      dec_sh_q <= '0;
      cnt_q    <= '0;
      duty_q   <= 4'd5;
      pwm_q    <= 1'b0;
    end else begin
      pre_q    <= pre_q + 2'd1;
      meta_q   <= {ui_decrease_duty, ui_increase_duty};
      sync_q   <= meta_q;
      inc_sh_q <= inc_sh_d;
      dec_sh_q <= dec_sh_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      pwm_q    <= cnt_q < duty_q;
    end
  assign uo_PWM_OUT = pwm_q;
endmodule

// File: tb/tb_tt_um_pwm_generator_verilog.sv
// tb_tt_um_pwm_generator_verilog: scoreboard bench with a behavioural PWM/debounce model
module tb_tt_um_pwm_generator_verilog;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ena = 1'b1;
  logic inc = 1'b0;
  logic dec = 1'b0;
  logic uo;
  int checks = 0;
  int failures = 0;

  tt_um_pwm_generator_verilog dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .ui_increase_duty(inc), .ui_decrease_duty(dec),
    .uo_PWM_OUT(uo)
  );

  always #5 clk = ~clk;

  // Reference model: k counts edges since reset release; inputs reach the debouncer
  // two edges late, are sampled on every 4th edge, and the duty steps on a 0,1,1 sample run.
  int k;
  int m_duty;
  bit inc_h[$], dec_h[$], si[$], sd[$], exp_q[$];
  bit e, pi, pd;
  int n;
  initial forever begin
    @(posedge clk);
    if (rst_n) begin
      k = 0;
      m_duty = 5;
      inc_h.delete();
      dec_h.delete();
      si = '{0, 0, 0};
      sd = '{0, 0, 0};
      exp_q.push_back(1'b0);
    end else begin
      e = (k % 10) < m_duty;
      inc_h.push_back(inc);
      dec_h.push_back(dec);
      pi = 1'b0;
      pd = 1'b0;
      if (k % 4 == 3) begin
        si.push_back(k >= 2 ? inc_h[k-2] : 1'b0);
        sd.push_back(k >= 2 ? dec_h[k-2] : 1'b0);
        n = si.size();
        pi = si[n-1] && si[n-2] && !si[n-3];
        pd = sd[n-1] && sd[n-2] && !sd[n-3];
      end
      if (pi && !pd && m_duty < 10) m_duty++;
      if (pd && !pi && m_duty > 0) m_duty--;
      exp_q.push_back(e);
      k++;
    end
  end

  bit got_e;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty cycle=%0d got=%b required=<expected entry>", cyc, uo);
    end else begin
      got_e = exp_q.pop_front();
      if (uo !== got_e) begin
        failures++;
        $display("FAIL pwm_out cycle=%0d got=%b required=%b", cyc, uo, got_e);
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic count_high(output int h);
    h = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      h += int'(uo);
    end
  endtask

  task automatic press(input bit i, input bit d, input int hi, input int lo);
    @(negedge clk);
    inc = i;
    dec = d;
    repeat (hi) @(negedge clk);
    inc = 1'b0;
    dec = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic period_is(input string name, input int req);
    int h;
    count_high(h);
    chk(name, h, req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int h;
  bit seen;
  initial begin
    repeat (5) @(negedge clk);
    #1 chk("reset_out", int'(uo), 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 chk("first_edge_high", int'(uo), 1);
    period_is("default_5", 5);
    period_is("default_5_again", 5);
    repeat (3) press(1, 0, 10, 10);
    period_is("three_inc_8", 8);
    repeat (3) press(0, 1, 10, 10);
    period_is("three_dec_5", 5);
    do_reset();
    repeat (7) press(1, 0, 10, 10);
    period_is("sat_high_10", 10);
    press(1, 0, 10, 10);
    period_is("sat_high_hold", 10);
    repeat (11) press(0, 1, 10, 10);
    period_is("sat_low_0", 0);
    do_reset();
    press(1, 0, 3, 12);
    period_is("glitch_reject", 5);
    press(1, 1, 12, 12);
    period_is("both_no_change", 5);
    press(1, 0, 40, 10);
    period_is("long_hold_6", 6);
    do_reset();
    repeat (3) press(1, 0, 10, 10);
    period_is("pre_async_8", 8);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1 seen = uo;
    end
    chk("async_wait_high", int'(seen), 1);
    #2 rst_n = 1'b1;
    #1 chk("async_reset_out", int'(uo), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    period_is("post_async_5", 5);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: press(1, 0, $urandom_range(1, 14), $urandom_range(1, 12));
        1: press(0, 1, $urandom_range(1, 14), $urandom_range(1, 12));
        default: press(1, 1, $urandom_range(1, 14), $urandom_range(1, 12));
      endcase
    end
    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
